mem_access_stage: RTL and testbench
===================================

# mem_access_stage

MEM stage of the 5-stage MIPS pipeline: consumes the EX/MEM register outputs (MemWrite, MemRead, WB controls, ALU result, destination register, store data), runs a request/acknowledge transaction to the data memory, and holds the MEM/WB pipeline register feeding writeback. A wait-state FSM freezes the upstream pipeline while memory is slow and inserts a writeback bubble for each stalled cycle.

## Interface
- ADDR_W, 32, data memory address width.
- DATA_W, 32, data word width.
- REG_W, 5, destination register index width.
- clk  in  1  clock; reset reset, asynchronous, active-high.
- reset  in  1  see clk.
- mem_write_i  in  1  store request from EX/MEM.
- mem_read_i  in  1  load request from EX/MEM.
- wb_i  in  2  writeback controls {RegWrite, MemtoReg}.
- alu_i  in  ADDR_W  ALU result; memory address for loads/stores.
- rd_i  in  REG_W  destination register index.
- store_data_i  in  DATA_W  store data (rt value).
- dmem_req_o  out  1  memory request valid.
- dmem_we_o  out  1  1 = write, 0 = read.
- dmem_addr_o  out  ADDR_W  request address.
- dmem_wdata_o  out  DATA_W  write data.
- dmem_ack_i  in  1  memory completes request this cycle.
- dmem_rdata_i  in  DATA_W  read data, valid when dmem_ack_i=1 on a read.
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle.
- wb_o  out  2  registered writeback controls.
- mem_data_o  out  DATA_W  registered load data.
- alu_o  out  ADDR_W  registered ALU result.
- rd_o  out  REG_W  registered destination index.
- align_err_o  out  1  misaligned access flag (see Configuration).

## Operation
- access = mem_read_i | mem_write_i (qualified by alignment when checking is enabled).
- FSM states IDLE, WAIT. Reset state IDLE.
- IDLE: access=1 -> dmem_req_o=1 same cycle; dmem_ack_i=1 -> complete, stay IDLE; else -> WAIT.
- WAIT: dmem_req_o=1 held; dmem_ack_i=1 -> complete, -> IDLE; else stay WAIT.
- dmem_addr_o=alu_i, dmem_wdata_o=store_data_i, dmem_we_o=mem_write_i, all combinational; stable during WAIT because upstream is frozen.
- stall_o = access & ~dmem_ack_i (combinational, either state).
- MEM/WB capture on every posedge where stall_o=0: wb_o<=wb_i, alu_o<=alu_i, rd_o<=rd_i, mem_data_o<=dmem_rdata_i on completed read, else 0.
- Stall cycle: wb_o<=2'b00 (bubble); alu_o, rd_o, mem_data_o hold.
- mem_read_i and mem_write_i both 1: write wins, mem_data_o<=0.
- dmem_ack_i with no access: ignored.

## Timing
- Reset (async): state=IDLE, wb_o=0, mem_data_o=0, alu_o=0, rd_o=0, align_err_o=0; dmem_req_o falls immediately; in-flight transaction abandoned, later stray ack ignored.
- Zero-wait memory (ack in request cycle): 0 stall cycles, results on next posedge.
- N wait cycles before ack: stall_o high N cycles, N bubbles, result captured on ack-cycle posedge.
- Non-memory instructions: pure 1-cycle register, no stall.

## Configuration
- MEM_ALIGN_CHECK_EN defined: access with alu_i[1:0]!=0 issues no request and no stall; align_err_o<=1 for one cycle (registered), wb_o<=0 (writeback suppressed).
- Undefined: no check; address passed unmodified; align_err_o tied 0 (port retained).

## Structure
- Shared pkg mem_pkg: FSM state enum (IDLE, WAIT), WB field bit positions (WB_REGWRITE=1, WB_MEMTOREG=0).
- Sub-module mem_wb_reg: MEM/WB register with capture and bubble inputs; FSM and handshake logic stay in mem_access_stage.

## Test plan
- Reset asserted during WAIT (addr 0x40 load pending) -> dmem_req_o=0 immediately, all outputs 0, state IDLE; ack one cycle later ignored.
- Load addr 0x10, ack same cycle, rdata 0xDEADBEEF, wb_i=2'b11, rd_i=8 -> stall_o never high; next cycle wb_o=2'b11, mem_data_o=0xDEADBEEF, rd_o=8.
- Store addr 0x20 data 0x1234, ack after 3 cycles -> stall_o high 3 cycles, dmem_we_o=1 throughout, wb_o=0 during stall, capture on ack.
- ADD (no mem access) alu_i=0x7, wb_i=2'b10, rd_i=3 -> dmem_req_o=0, next cycle alu_o=0x7, wb_o=2'b10, rd_o=3, mem_data_o=0.
- Read and write both 1, addr 0x8 -> dmem_we_o=1, mem_data_o=0 after ack.
- With MEM_ALIGN_CHECK_EN: load addr 0x12 -> no request, no stall, align_err_o=1 for one cycle, wb_o=0; without macro -> request issued to 0x12.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the MEM stage: wait-state FSM encoding and writeback-control bit positions.
package mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int WB_W        = 2;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads the stage results on capture, inserts a writeback bubble on stall.
// Latency 1 cycle; during a bubble only the writeback controls and the error flag are cleared.
import mem_pkg::*;

module mem_wb_reg #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture_i,
  input  logic              bubble_i,
  input  logic [WB_W-1:0]   wb_i,
  input  logic [ADDR_W-1:0] alu_i,
  input  logic [REG_W-1:0]  rd_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              align_err_i,
  output logic [WB_W-1:0]   wb_o,
  output logic [ADDR_W-1:0] alu_o,
  output logic [REG_W-1:0]  rd_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              align_err_o
);

  logic [WB_W-1:0]   wb_d, wb_q;
  logic [ADDR_W-1:0] alu_d, alu_q;
  logic [REG_W-1:0]  rd_d, rd_q;
  logic [DATA_W-1:0] mem_data_d, mem_data_q;
  logic              align_err_d, align_err_q;

  always_comb begin
    wb_d        = wb_q;
    alu_d       = alu_q;
    rd_d        = rd_q;
    mem_data_d  = mem_data_q;
    align_err_d = align_err_q;
    if (bubble_i) begin
      // Address/data fields hold so the writeback stage sees a stable, inert slot.
      wb_d        = '0;
      align_err_d = 1'b0;
    end else if (capture_i) begin
      wb_d        = wb_i;
      alu_d       = alu_i;
      rd_d        = rd_i;
      mem_data_d  = mem_data_i;
      align_err_d = align_err_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_q        <= '0;
      alu_q       <= '0;
      rd_q        <= '0;
      mem_data_q  <= '0;
      align_err_q <= 1'b0;
    end else begin
      wb_q        <= wb_d;
      alu_q       <= alu_d;
      rd_q        <= rd_d;
      mem_data_q  <= mem_data_d;
      align_err_q <= align_err_d;
    end
  end

  assign wb_o        = wb_q;
  assign alu_o       = alu_q;
  assign rd_o        = rd_q;
  assign mem_data_o  = mem_data_q;
  assign align_err_o = align_err_q;

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: req/ack data-memory access feeding the MEM/WB register; stall_o freezes upstream
// while memory is slow (one WB bubble per stalled cycle). MEM_ALIGN_CHECK_EN enables misalignment trapping.
import mem_pkg::*;

module mem_access_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_write_i,
  input  logic              mem_read_i,
  input  logic [1:0]        wb_i,
  input  logic [ADDR_W-1:0] alu_i,
  input  logic [REG_W-1:0]  rd_i,
  input  logic [DATA_W-1:0] store_data_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              stall_o,
  output logic [1:0]        wb_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] alu_o,
  output logic [REG_W-1:0]  rd_o,
  output logic              align_err_o
);

  state_t            state_d, state_q;
  logic              access_raw;
  logic              misaligned;
  logic              access;
  logic              done;
  logic              stall;
  logic              req;
  logic [WB_W-1:0]   wb_eff;
  logic [DATA_W-1:0] load_data;

  assign access_raw = mem_read_i | mem_write_i;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = access_raw & (alu_i[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // A misaligned access never reaches memory, so it neither requests nor stalls.
  assign access = access_raw & ~misaligned;
  assign done   = access & dmem_ack_i;
  assign stall  = access & ~dmem_ack_i & ~reset;

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    case (state_q)
      IDLE: begin
        req = access;
        if (access && !dmem_ack_i) state_d = WAIT;
      end
      WAIT: begin
        req = 1'b1;
        if (dmem_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Request drops the moment reset asserts, abandoning any in-flight access.
  assign dmem_req_o   = req & ~reset;
  assign dmem_we_o    = mem_write_i;
  assign dmem_addr_o  = alu_i;
  assign dmem_wdata_o = store_data_i;
  assign stall_o      = stall;

  // Write wins when both read and write are asserted, so no load data is returned.
  assign load_data = (done && mem_read_i && !mem_write_i) ? dmem_rdata_i : '0;

  always_comb begin
    wb_eff              = '0;
    wb_eff[WB_REGWRITE] = wb_i[WB_REGWRITE] & ~misaligned;
    wb_eff[WB_MEMTOREG] = wb_i[WB_MEMTOREG] & ~misaligned;
  end

  mem_wb_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_mem_wb_reg (
    .clk         (clk),
    .reset       (reset),
    .capture_i   (~stall),
    .bubble_i    (stall),
    .wb_i        (wb_eff),
    .alu_i       (alu_i),
    .rd_i        (rd_i),
    .mem_data_i  (load_data),
    .align_err_i (misaligned),
    .wb_o        (wb_o),
    .alu_o       (alu_o),
    .rd_o        (rd_o),
    .mem_data_o  (mem_data_o),
    .align_err_o (align_err_o)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: inputs driven on negedge, outputs sampled #1 after edges.
module tb_mem_access_stage;

  logic        clk;
  logic        reset;
  logic        mem_write_i;
  logic        mem_read_i;
  logic [1:0]  wb_i;
  logic [31:0] alu_i;
  logic [4:0]  rd_i;
  logic [31:0] store_data_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        stall_o;
  logic [1:0]  wb_o;
  logic [31:0] mem_data_o;
  logic [31:0] alu_o;
  logic [4:0]  rd_o;
  logic        align_err_o;

  int total = 0;
  int bad   = 0;

  mem_access_stage dut (
    .clk          (clk),
    .reset        (reset),
    .mem_write_i  (mem_write_i),
    .mem_read_i   (mem_read_i),
    .wb_i         (wb_i),
    .alu_i        (alu_i),
    .rd_i         (rd_i),
    .store_data_i (store_data_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i),
    .stall_o      (stall_o),
    .wb_o         (wb_o),
    .mem_data_o   (mem_data_o),
    .alu_o        (alu_o),
    .rd_o         (rd_o),
    .align_err_o  (align_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    mem_write_i  = 1'b0;
    mem_read_i   = 1'b0;
    wb_i         = 2'b00;
    alu_i        = 32'h0;
    rd_i         = 5'd0;
    store_data_i = 32'h0;
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    #12;
    total++; if (wb_o !== 2'b00) begin bad++; $display("FAIL rst_wb got %b exp 00", wb_o); end
    total++; if (mem_data_o !== 32'h0) begin bad++; $display("FAIL rst_mem_data got %h exp 0", mem_data_o); end
    total++; if (alu_o !== 32'h0 || rd_o !== 5'd0) begin bad++; $display("FAIL rst_alu_rd got %h/%0d exp 0/0", alu_o, rd_o); end
    total++; if (align_err_o !== 1'b0 || dmem_req_o !== 1'b0) begin bad++; $display("FAIL rst_err_req got %b/%b exp 0/0", align_err_o, dmem_req_o); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_load_zero_wait();
    @(negedge clk);
    mem_read_i = 1'b1; alu_i = 32'h10; wb_i = 2'b11; rd_i = 5'd8;
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hDEADBEEF;
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL ld0_stall got %b exp 0", stall_o); end
    total++; if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b0 || dmem_addr_o !== 32'h10) begin
      bad++; $display("FAIL ld0_req got req=%b we=%b addr=%h exp 1/0/10", dmem_req_o, dmem_we_o, dmem_addr_o); end
    @(posedge clk); #1;
    total++; if (wb_o !== 2'b11) begin bad++; $display("FAIL ld0_wb got %b exp 11", wb_o); end
    total++; if (mem_data_o !== 32'hDEADBEEF) begin bad++; $display("FAIL ld0_data got %h exp deadbeef", mem_data_o); end
    total++; if (rd_o !== 5'd8 || alu_o !== 32'h10) begin bad++; $display("FAIL ld0_rd_alu got %0d/%h exp 8/10", rd_o, alu_o); end
  endtask

  task automatic test_add();
    @(negedge clk);
    drive_idle();
    alu_i = 32'h7; wb_i = 2'b10; rd_i = 5'd3;
    #1;
    total++; if (dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin bad++; $display("FAIL add_req got req=%b stall=%b exp 0/0", dmem_req_o, stall_o); end
    @(posedge clk); #1;
    total++; if (alu_o !== 32'h7 || wb_o !== 2'b10 || rd_o !== 5'd3) begin
      bad++; $display("FAIL add_regs got alu=%h wb=%b rd=%0d exp 7/10/3", alu_o, wb_o, rd_o); end
    total++; if (mem_data_o !== 32'h0) begin bad++; $display("FAIL add_mem_data got %h exp 0", mem_data_o); end
  endtask

  task automatic test_store_wait();
    @(negedge clk);
    drive_idle();
    mem_write_i = 1'b1; alu_i = 32'h20; store_data_i = 32'h1234; wb_i = 2'b00; rd_i = 5'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (stall_o !== 1'b1 || dmem_req_o !== 1'b1 || dmem_we_o !== 1'b1) begin
        bad++; $display("FAIL st_wait%0d got stall=%b req=%b we=%b exp 1/1/1", i, stall_o, dmem_req_o, dmem_we_o); end
      total++; if (dmem_wdata_o !== 32'h1234 || dmem_addr_o !== 32'h20) begin
        bad++; $display("FAIL st_bus%0d got wdata=%h addr=%h exp 1234/20", i, dmem_wdata_o, dmem_addr_o); end
      @(posedge clk); #1;
      total++; if (wb_o !== 2'b00 || alu_o !== 32'h7 || rd_o !== 5'd3) begin
        bad++; $display("FAIL st_bubble%0d got wb=%b alu=%h rd=%0d exp 00/7/3", i, wb_o, alu_o, rd_o); end
      @(negedge clk);
    end
    dmem_ack_i = 1'b1;
    #1;
    total++; if (stall_o !== 1'b0 || dmem_req_o !== 1'b1 || dmem_we_o !== 1'b1) begin
      bad++; $display("FAIL st_ack got stall=%b req=%b we=%b exp 0/1/1", stall_o, dmem_req_o, dmem_we_o); end
    @(posedge clk); #1;
    total++; if (alu_o !== 32'h20 || rd_o !== 5'd0 || wb_o !== 2'b00 || mem_data_o !== 32'h0) begin
      bad++; $display("FAIL st_capture got alu=%h rd=%0d wb=%b data=%h exp 20/0/00/0", alu_o, rd_o, wb_o, mem_data_o); end
  endtask

  task automatic test_read_write_both();
    @(negedge clk);
    drive_idle();
    mem_read_i = 1'b1; alu_i = 32'h4; wb_i = 2'b11; rd_i = 5'd2;
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h0BADF00D;
    @(posedge clk); #1;
    total++; if (mem_data_o !== 32'h0BADF00D) begin bad++; $display("FAIL rw_pre got %h exp 0badf00d", mem_data_o); end
    @(negedge clk);
    mem_write_i = 1'b1; mem_read_i = 1'b1; alu_i = 32'h8; store_data_i = 32'h55; wb_i = 2'b10; rd_i = 5'd9;
    dmem_ack_i = 1'b0; dmem_rdata_i = 32'hCAFEF00D;
    #1;
    total++; if (dmem_we_o !== 1'b1 || stall_o !== 1'b1) begin bad++; $display("FAIL rw_we got we=%b stall=%b exp 1/1", dmem_we_o, stall_o); end
    @(negedge clk);
    dmem_ack_i = 1'b1;
    #1;
    total++; if (dmem_we_o !== 1'b1 || stall_o !== 1'b0) begin bad++; $display("FAIL rw_ack got we=%b stall=%b exp 1/0", dmem_we_o, stall_o); end
    @(posedge clk); #1;
    total++; if (mem_data_o !== 32'h0 || alu_o !== 32'h8 || rd_o !== 5'd9) begin
      bad++; $display("FAIL rw_capture got data=%h alu=%h rd=%0d exp 0/8/9", mem_data_o, alu_o, rd_o); end
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    drive_idle();
    alu_i = 32'h7; wb_i = 2'b10; rd_i = 5'd3;
    @(negedge clk);
    mem_read_i = 1'b1; alu_i = 32'h40; wb_i = 2'b11; rd_i = 5'd5;
    #1;
    total++; if (stall_o !== 1'b1 || dmem_req_o !== 1'b1) begin bad++; $display("FAIL rw8_req got stall=%b req=%b exp 1/1", stall_o, dmem_req_o); end
    @(posedge clk); #1;
    total++; if (wb_o !== 2'b00 || alu_o !== 32'h7 || rd_o !== 5'd3) begin
      bad++; $display("FAIL rwait_hold got wb=%b alu=%h rd=%0d exp 00/7/3", wb_o, alu_o, rd_o); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (dmem_req_o !== 1'b0) begin bad++; $display("FAIL rwait_req_drop got %b exp 0", dmem_req_o); end
    total++; if (wb_o !== 2'b00 || alu_o !== 32'h0 || rd_o !== 5'd0 || mem_data_o !== 32'h0 || align_err_o !== 1'b0) begin
      bad++; $display("FAIL rwait_outs got wb=%b alu=%h rd=%0d data=%h err=%b exp all 0", wb_o, alu_o, rd_o, mem_data_o, align_err_o); end
    drive_idle();
    @(negedge clk);
    reset = 1'b0;
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h12345678;
    #1;
    total++; if (dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin bad++; $display("FAIL stray_req got req=%b stall=%b exp 0/0", dmem_req_o, stall_o); end
    @(posedge clk); #1;
    total++; if (mem_data_o !== 32'h0 || wb_o !== 2'b00) begin bad++; $display("FAIL stray_ack got data=%h wb=%b exp 0/00", mem_data_o, wb_o); end
    @(negedge clk);
    drive_idle();
    // IDLE after reset: a fresh load with immediate ack completes without stalling.
    mem_read_i = 1'b1; alu_i = 32'h44; wb_i = 2'b11; rd_i = 5'd6; dmem_ack_i = 1'b1; dmem_rdata_i = 32'hA5A5A5A5;
    #1;
    total++; if (stall_o !== 1'b0 || dmem_req_o !== 1'b1) begin bad++; $display("FAIL post_rst_req got stall=%b req=%b exp 0/1", stall_o, dmem_req_o); end
    @(posedge clk); #1;
    total++; if (mem_data_o !== 32'hA5A5A5A5 || rd_o !== 5'd6) begin bad++; $display("FAIL post_rst_data got %h/%0d exp a5a5a5a5/6", mem_data_o, rd_o); end
  endtask

  task automatic test_align();
    @(negedge clk);
    drive_idle();
    mem_read_i = 1'b1; alu_i = 32'h12; wb_i = 2'b11; rd_i = 5'd4; dmem_ack_i = 1'b1; dmem_rdata_i = 32'h55;
    #1;
`ifdef MEM_ALIGN_CHECK_EN
    total++; if (dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin bad++; $display("FAIL align_req got req=%b stall=%b exp 0/0", dmem_req_o, stall_o); end
    @(posedge clk); #1;
    total++; if (align_err_o !== 1'b1 || wb_o !== 2'b00) begin bad++; $display("FAIL align_err got err=%b wb=%b exp 1/00", align_err_o, wb_o); end
    @(negedge clk);
    drive_idle();
    @(posedge clk); #1;
    total++; if (align_err_o !== 1'b0) begin bad++; $display("FAIL align_pulse got %b exp 0", align_err_o); end
`else
    total++; if (dmem_req_o !== 1'b1 || dmem_addr_o !== 32'h12 || stall_o !== 1'b0) begin
      bad++; $display("FAIL noalign_req got req=%b addr=%h stall=%b exp 1/12/0", dmem_req_o, dmem_addr_o, stall_o); end
    @(posedge clk); #1;
    total++; if (align_err_o !== 1'b0 || wb_o !== 2'b11 || mem_data_o !== 32'h55) begin
      bad++; $display("FAIL noalign_cap got err=%b wb=%b data=%h exp 0/11/55", align_err_o, wb_o, mem_data_o); end
`endif
  endtask

  initial begin
    test_reset();
    test_load_zero_wait();
    test_add();
    test_store_wait();
    test_read_write_both();
    test_reset_in_wait();
    test_align();
    @(negedge clk);
    drive_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
